// File: rtl/butterfly_pipe_if.sv
// Handshake and data bundle between the twiddle rotator, the butterfly and the
// stage memory. The butterfly takes the slave view; its driver takes the master view.
interface butterfly_pipe_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    // input side
    logic              i_valid;
    logic              o_ready;
    logic              i_scale;
    logic              i_sat;
    logic [DATA_W-1:0] i_A_real;
    logic [DATA_W-1:0] i_A_imag;
    logic [DATA_W-1:0] i_B_real;
    logic [DATA_W-1:0] i_B_imag;

    // output side
    logic              o_valid;
    logic              i_ready;
    logic [DATA_W-1:0] o_A_new_real;
    logic [DATA_W-1:0] o_A_new_imag;
    logic [DATA_W-1:0] o_B_new_real;
    logic [DATA_W-1:0] o_B_new_imag;

    // status
    logic              o_ovf;
    logic              i_ovf_clr;
    logic [CNT_W-1:0]  o_beat_cnt;

    modport slave (
        input  i_valid, i_scale, i_sat, i_A_real, i_A_imag, i_B_real, i_B_imag,
        output o_ready,
        output o_valid, o_A_new_real, o_A_new_imag, o_B_new_real, o_B_new_imag,
        input  i_ready,
        output o_ovf, o_beat_cnt,
        input  i_ovf_clr
    );

    modport master (
        output i_valid, i_scale, i_sat, i_A_real, i_A_imag, i_B_real, i_B_imag,
        input  o_ready,
        input  o_valid, o_A_new_real, o_A_new_imag, o_B_new_real, o_B_new_imag,
        output i_ready,
        input  o_ovf, o_beat_cnt,
        output i_ovf_clr
    );
endinterface

// File: rtl/butterfly_pipe.sv
// Radix-2 butterfly: A' = A + B, B' = A - B on complex fixed point operands.
// Two register stages (wide sum/diff, then scale/saturate/wrap) with a
// valid/ready handshake, per-beat mode bits, sticky overflow and a beat counter.

// One output lane: reduces a DATA_W+1 bit sum/diff to DATA_W bits.
module butterfly_lane #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W:0]   x,
    input  logic              scale,
    input  logic              sat,
    output logic [DATA_W-1:0] y,
    output logic              ovf
);
    localparam logic [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};

    // (x + 1) >>> 1 written as (x >>> 1) + x[0]: same value, no spare LSB
    logic [DATA_W:0] rnd;
    logic            out_of_range;

    assign rnd          = {x[DATA_W], x[DATA_W:1]} + {{DATA_W{1'b0}}, x[0]};
    assign out_of_range = x[DATA_W] ^ x[DATA_W-1];

    // select scaled, saturated or wrapped result for this lane
    always_comb begin
        y   = x[DATA_W-1:0];
        ovf = 1'b0;
        if (scale) begin
            // Only a difference of (max - min) rounds up to +2^(DATA_W-1);
            // pin it to the positive bound instead of letting it flip sign.
            // Scaled beats never report overflow.
            if (rnd[DATA_W] != rnd[DATA_W-1]) begin
                y = MAX_V;
            end else begin
                y = rnd[DATA_W-1:0];
            end
        end else if (out_of_range) begin
            ovf = 1'b1;
            if (sat) begin
                y = x[DATA_W] ? MIN_V : MAX_V;
            end
        end
    end
endmodule

module butterfly_pipe #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic           i_clk,
    input  logic           i_reset,
    butterfly_pipe_if.slave bus
);
    localparam int NUM_LANES = 4;  // 0: sum_r, 1: sum_i, 2: dif_r, 3: dif_i
    localparam int STAGES    = 2;

    typedef struct packed {
        logic scale;
        logic sat;
    } mode_t;

    // pipeline control
    logic [STAGES:1] vld_pipe;
    logic            en1;
    logic            en2;
    logic            accept;
    logic            handoff;

    // stage 0 (combinational) operands and lanes
    logic [DATA_W:0]                   a_r;
    logic [DATA_W:0]                   a_i;
    logic [DATA_W:0]                   b_r;
    logic [DATA_W:0]                   b_i;
    logic [NUM_LANES-1:0][DATA_W:0]    s0_lane;
    mode_t                             s0_mode;

    // stage 1 registers
    logic [NUM_LANES-1:0][DATA_W:0]    s1_lane;
    mode_t                             s1_mode;

    // stage 2 datapath and registers
    logic [NUM_LANES-1:0][DATA_W-1:0]  lane_y;
    logic [NUM_LANES-1:0]              lane_ovf;
    logic [NUM_LANES-1:0][DATA_W-1:0]  s2_lane;
    logic                              ovf_set;
    logic                              ovf_q;
    logic [CNT_W-1:0]                  cnt_q;

    // A stage may load when it is empty or its contents move on this cycle;
    // o_ready follows i_ready combinationally so a full pipe streams at 1/cycle.
    assign en2     = ~vld_pipe[2] | bus.i_ready;
    assign en1     = ~vld_pipe[1] | en2;
    assign accept  = bus.i_valid & en1;
    assign handoff = vld_pipe[2] & bus.i_ready;

    // sign-extend by one bit so sum/diff cannot wrap in stage 1
    assign a_r = {bus.i_A_real[DATA_W-1], bus.i_A_real};
    assign a_i = {bus.i_A_imag[DATA_W-1], bus.i_A_imag};
    assign b_r = {bus.i_B_real[DATA_W-1], bus.i_B_real};
    assign b_i = {bus.i_B_imag[DATA_W-1], bus.i_B_imag};

    assign s0_lane[0]    = a_r + b_r;
    assign s0_lane[1]    = a_i + b_i;
    assign s0_lane[2]    = a_r - b_r;
    assign s0_lane[3]    = a_i - b_i;
    assign s0_mode.scale = bus.i_scale;
    assign s0_mode.sat   = bus.i_sat;

    // valid shift register; each bit advances only when its stage is enabled
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            vld_pipe <= '0;
        end else begin
            if (en1) vld_pipe[1] <= accept;
            if (en2) vld_pipe[2] <= vld_pipe[1];
        end
    end

    // stage 1: capture wide lanes and the beat's mode bits
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            s1_lane <= '0;
            s1_mode <= '0;
        end else if (en1) begin
            s1_lane <= s0_lane;
            s1_mode <= s0_mode;
        end
    end

    // per-lane reduction to DATA_W bits
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        butterfly_lane #(
            .DATA_W (DATA_W)
        ) lane_u (
            .x     (s1_lane[l]),
            .scale (s1_mode.scale),
            .sat   (s1_mode.sat),
            .y     (lane_y[l]),
            .ovf   (lane_ovf[l])
        );
    end

    // stage 2: result registers hold while the output is stalled
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            s2_lane <= '0;
        end else if (en2) begin
            s2_lane <= lane_y;
        end
    end

    // Only a real beat moving into stage 2 may raise the flag, so garbage
    // captured on idle cycles never reaches it. A set beats a same-cycle clear.
    assign ovf_set = vld_pipe[1] & en2 & (|lane_ovf);

    // sticky overflow flag
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_set | (ovf_q & ~bus.i_ovf_clr);
        end
    end

    // count output handshakes, wrapping naturally
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else if (handoff) begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.o_ready      = en1;
    assign bus.o_valid      = vld_pipe[2];
    assign bus.o_A_new_real = s2_lane[0];
    assign bus.o_A_new_imag = s2_lane[1];
    assign bus.o_B_new_real = s2_lane[2];
    assign bus.o_B_new_imag = s2_lane[3];
    assign bus.o_ovf        = ovf_q;
    assign bus.o_beat_cnt   = cnt_q;
endmodule
